// File: rtl/sr64_tx_sequencer_pkg.sv
// Shared types and sizing for the 64-bit shift-register transmit sequencer.
package sr_pkg;

    localparam int unsigned SR_N     = 64;
    localparam int unsigned SR_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } sr_state_t;

endpackage

// File: rtl/sr64_tx_sequencer_if.sv
// Parallel-word valid/ready handshake into the transmit sequencer.
interface sr64_tx_sequencer_if #(
    parameter int unsigned N = 64
);
    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/sr64_tx_sequencer_bit_counter.sv
// Bit position counter for one shifted word; flags the final bit position N-1.
module sr_bit_counter #(
    parameter int unsigned N     = 64,
    parameter int unsigned CNT_W = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);
endmodule

// File: rtl/sr64_tx_sequencer.sv
// Framed parallel-to-serial transmitter driving an external N-bit universal shift register.
// Build option SR_MSB_FIRST_EN: shift toward bit N-1 and transmit MSB first.
module sr64_tx_sequencer
    import sr_pkg::*;
#(
    parameter int unsigned N     = SR_N,
    parameter int unsigned CNT_W = SR_CNT_W,
    parameter logic        FILL  = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    sr64_tx_sequencer_if.slave  tx,
    input  logic [N-1:0]        sr_data,
    output logic [N-1:0]        sr_par_in,
    output logic                sr_load,
    output logic                sr_mode,
    output logic                sr_serin,
    output logic                ser_out,
    output logic                ser_valid,
    output logic                ser_last,
    output logic                busy
);
    sr_state_t    state_q, state_d;
    logic         pend_q, pend_d;
    logic [N-1:0] hold_q, hold_d;
    logic         load_q, valid_q, busy_q;
    logic         xfer;
    logic         cnt_tc;
    logic         unused_sr_bits;

    assign tx.tx_ready = !pend_q;
    assign xfer        = tx.tx_valid && !pend_q;

    // IDLE looks at the next pend so an accepted word reaches LOAD on the accepting edge.
    always_comb begin
        hold_d  = xfer ? tx.tx_data : hold_q;
        pend_d  = pend_q;
        if (state_q == LOAD) pend_d = 1'b0;
        if (xfer)            pend_d = 1'b1;
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pend_d) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cnt_tc) state_d = pend_d ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            hold_q  <= '0;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            load_q  <= (state_d == LOAD);
            valid_q <= (state_d == SHIFT);
            busy_q  <= (state_d != IDLE);
        end
    end

    sr_bit_counter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clock   (clock),
        .reset   (reset),
        .clear_i (state_q == LOAD),
        .en_i    (state_q == SHIFT),
        .tc_o    (cnt_tc)
    );

    assign sr_load   = load_q;
    assign sr_par_in = load_q ? hold_q : '0;
    assign sr_serin  = FILL;
    assign ser_valid = valid_q;
    assign ser_last  = valid_q && cnt_tc;
    assign busy      = busy_q;

`ifdef SR_MSB_FIRST_EN
    assign sr_mode = 1'b1;
    assign ser_out = sr_data[N-1];
`else
    assign sr_mode = 1'b0;
    assign ser_out = sr_data[0];
`endif

    assign unused_sr_bits = ^sr_data;
endmodule

// File: tb/tb_sr64_tx_sequencer.sv
`timescale 1ns/1ps
module tb_sr64_tx_sequencer;
    import sr_pkg::*;

    localparam int N = SR_N;
`ifdef SR_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sr64_tx_sequencer_if #(.N(N)) tx_if ();

    logic [N-1:0] sr_data, sr_par_in;
    logic sr_load, sr_mode, sr_serin, ser_out, ser_valid, ser_last, busy;

    sr64_tx_sequencer #(.N(N), .CNT_W(SR_CNT_W), .FILL(1'b0)) dut (
        .clock     (clock),
        .reset     (reset),
        .tx        (tx_if.slave),
        .sr_data   (sr_data),
        .sr_par_in (sr_par_in),
        .sr_load   (sr_load),
        .sr_mode   (sr_mode),
        .sr_serin  (sr_serin),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    // Universal shift register the sequencer drives; starts non-zero so draining is visible.
    logic [N-1:0] sr_q = 64'hFFFF_0000_FFFF_0000;
    always @(posedge clock) begin
        if (sr_load)      sr_q <= sr_par_in;
        else if (sr_mode) sr_q <= {sr_q[N-2:0], sr_serin};
        else              sr_q <= {sr_serin, sr_q[N-1:1]};
    end
    assign sr_data = sr_q;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction schedule: word k accepted at edge m_e[k], its LOAD cycle is m_l[k],
    // bits follow in cycles m_l[k]+1 .. m_l[k]+N.
    int           m_e[$];
    int           m_l[$];
    logic [N-1:0] m_w[$];
    int           last_l = -1000;

    logic [N-1:0] rx_word;
    int           rx_i = 0;
    logic         rx_first;
    logic [N-1:0] rx_q[$];
    logic         rx_first_q[$];
    logic         rx_last_q[$];

    typedef struct {
        logic [63:0] data;
        int unsigned gap;
        logic        first_lsb;
        logic        first_msb;
        int unsigned exp_wait;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready(input int c);
        foreach (m_e[k]) if (m_e[k] <= c && c <= m_l[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_expect(input int c, output bit v, output bit ld, output bit bz,
                            output bit lst, output bit b);
        logic [N-1:0] w;
        int j;
        v = 0; ld = 0; bz = 0; lst = 0; b = 0;
        foreach (m_l[k]) begin
            if (c == m_l[k]) ld = 1;
            if (c >= m_l[k] && c <= m_l[k] + N) bz = 1;
            if (c > m_l[k] && c <= m_l[k] + N) begin
                w   = m_w[k];
                j   = c - m_l[k] - 1;
                v   = 1;
                lst = (j == N - 1);
                b   = MSB_FIRST ? w[N-1-j] : w[j];
            end
        end
    endtask

    task automatic m_reset();
        m_e.delete(); m_l.delete(); m_w.delete();
        last_l = -1000;
        rx_i   = 0;
    endtask

    task automatic check_cycle();
        bit v, ld, bz, lst, b;
        int idx;
        m_expect(cyc, v, ld, bz, lst, b);
        chk("tx_ready",  tx_if.tx_ready, m_ready(cyc));
        chk("sr_load",   sr_load,   ld);
        chk("ser_valid", ser_valid, v);
        chk("busy",      busy,      bz);
        chk("ser_last",  ser_last,  lst);
        if (v) chk("ser_out", ser_out, b);
        chk("sr_mode",   sr_mode,   MSB_FIRST);
        chk("sr_serin",  sr_serin,  1'b0);
        if (ser_valid) begin
            idx = MSB_FIRST ? (N - 1 - rx_i) : rx_i;
            if (rx_i == 0) rx_first = ser_out;
            if (idx >= 0 && idx < N) rx_word[idx] = ser_out;
            rx_i++;
            if (ser_last) begin
                rx_q.push_back(rx_word);
                rx_first_q.push_back(rx_first);
                rx_last_q.push_back(ser_out);
                rx_i = 0;
            end
        end
    endtask

    task automatic tick();
        bit           acc;
        logic [N-1:0] d;
        int           l;
        acc = tx_if.tx_valid && m_ready(cyc) && !reset;
        d   = tx_if.tx_data;
        @(posedge clock);
        cyc++;
        if (acc) begin
            l = (cyc > last_l + N + 1) ? cyc : last_l + N + 1;
            m_e.push_back(cyc);
            m_l.push_back(l);
            m_w.push_back(d);
            last_l = l;
        end
        @(negedge clock);
        check_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        bit          was_ready;
        logic [N-1:0] word;

        vecs[0] = '{64'h0123_4567_89AB_CDEF, 70,  1'b1, 1'b0, 1};
        vecs[1] = '{64'hA5A5_A5A5_A5A5_A5A5, 0,   1'b1, 1'b1, 1};
        vecs[2] = '{64'hFFFF_FFFF_0000_0000, 0,   1'b0, 1'b1, 2};
        vecs[3] = '{64'h1357_9BDF_2468_ACE0, 140, 1'b0, 1'b0, 65};
        vecs[4] = '{64'h8000_0000_0000_0001, 70,  1'b1, 1'b1, 1};

        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        repeat (3) @(negedge clock);
        chk("rst_tx_ready",  tx_if.tx_ready, 1'b1);
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_sr_load",   sr_load,   1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_ser_last",  ser_last,  1'b0);
        chk("rst_sr_par_in", sr_par_in, '0);
        chk("rst_sr_serin",  sr_serin,  1'b0);
        reset = 1'b0;

        repeat (70) tick();
        chk("idle_drain", sr_q, '0);

        // Directed words: back-to-back with tx_valid held, and a third word blocked by a full hold.
        for (int i = 0; i < 5; i++) begin
            tx_if.tx_valid = 1'b1;
            tx_if.tx_data  = vecs[i].data;
            n = 0;
            do begin
                was_ready = tx_if.tx_ready;
                tick();
                n++;
            end while (!was_ready && n < 200);
            chk("accept_wait", n, vecs[i].exp_wait);
            if (vecs[i].gap > 0) begin
                tx_if.tx_valid = 1'b0;
                repeat (vecs[i].gap) tick();
            end
        end
        tx_if.tx_valid = 1'b0;
        repeat (80) tick();
        chk("table_word_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) begin
                chk("table_word",  rx_q[i], vecs[i].data);
                chk("table_first", rx_first_q[i], MSB_FIRST ? vecs[i].first_msb : vecs[i].first_lsb);
                chk("table_last",  rx_last_q[i],  MSB_FIRST ? vecs[i].first_lsb : vecs[i].first_msb);
            end
        end

        // Reset while bit 20 of a word is on the serial output.
        rx_q.delete(); rx_first_q.delete(); rx_last_q.delete();
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        tx_if.tx_valid = 1'b0;
        n = 0;
        while (cyc < last_l + 21 && n < 200) begin
            tick();
            n++;
        end
        chk("midword_in_shift", ser_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_ser_valid", ser_valid, 1'b0);
        chk("midrst_sr_load",   sr_load,   1'b0);
        chk("midrst_ser_last",  ser_last,  1'b0);
        chk("midrst_busy",      busy,      1'b0);
        chk("midrst_tx_ready",  tx_if.tx_ready, 1'b1);
        m_reset();
        repeat (2) tick();
        reset = 1'b0;
        word = 64'h0F1E_2D3C_4B5A_6978;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = word;
        tick();
        tx_if.tx_valid = 1'b0;
        repeat (80) tick();
        chk("postrst_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("postrst_word", rx_q[0], word);

        // Random traffic: busy phase then sparse phase, checked cycle by cycle against the schedule.
        m_reset();
        rx_q.delete(); rx_first_q.delete(); rx_last_q.delete();
        for (int i = 0; i < 1200; i++) begin
            tx_if.tx_valid = (i < 600) ? ($urandom_range(3, 0) != 0) : ($urandom_range(19, 0) == 0);
            tx_if.tx_data  = {$urandom, $urandom};
            tick();
        end
        tx_if.tx_valid = 1'b0;
        repeat (150) tick();
        chk("rand_word_count", rx_q.size(), m_w.size());
        for (int i = 0; i < rx_q.size() && i < m_w.size(); i++)
            chk("rand_word", rx_q[i], m_w[i]);
        chk("final_drain", sr_q, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
